// File: rtl/karsilastirici_pkg.sv
// Shared types for the serial comparator controller: FSM states, result
// encoding and the conversion from a result code to the three output flags.
package karsilastirici_pkg;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COMPARE = 2'd1,
      S_DONE    = 2'd2
   } durum_t;

   typedef enum logic [1:0] {
      SONUC_K = 2'd0,
      SONUC_E = 2'd1,
      SONUC_B = 2'd2
   } sonuc_t;

   // {AkB, AeB, AbB}
   function automatic logic [2:0] sonuc_bayrak(input sonuc_t s);
      logic [2:0] f;
      case (s)
         SONUC_K: f = 3'b100;
         SONUC_E: f = 3'b010;
         SONUC_B: f = 3'b001;
         default: f = 3'b000;
      endcase
      return f;
   endfunction

endpackage

// File: rtl/bit_karsilastirici.sv
// Existing 1-bit magnitude comparator; purely combinational.
module bit_karsilastirici (
   input  logic a,
   input  logic b,
   output logic AkB,
   output logic AeB,
   output logic AbB
);

   // One-hot less / equal / greater for a single bit pair.
   always_comb begin
      AkB = ~a & b;
      AeB = ~(a ^ b);
      AbB = a & ~b;
   end

endmodule

// File: rtl/seri_karsilastirici_denetleyici.sv
// Serial MSB-first comparator controller. Latches two N-bit operands and walks
// one bit pair per cycle through the shared bit_karsilastirici.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for start; result flags hold the last result
// S_COMPARE | busy; one bit pair per cycle, idx counts down from N-1
// S_DONE    | one-cycle done pulse, flags valid, then back to S_IDLE
module seri_karsilastirici_denetleyici
   import karsilastirici_pkg::*;
#(
   parameter int N           = 8,
   parameter int ERKEN_BITIR = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         AkB,
   output logic         AeB,
   output logic         AbB
);

   localparam int IW = (N > 1) ? $clog2(N) : 1;

   durum_t        state;
   durum_t        next_state;
   logic [N-1:0]  ra;
   logic [N-1:0]  rb;
   logic [IW-1:0] idx;
   logic          bit_kb;
   logic          bit_eb;
   logic          bit_bb;
   logic          fark;
   logic          karar_var;
   logic          karar_kb;
   logic          sonuc_yukle;
   sonuc_t        sonuc_d;
   logic          kabul;

   bit_karsilastirici u_bit (
      .a   (ra[idx]),
      .b   (rb[idx]),
      .AkB (bit_kb),
      .AeB (bit_eb),
      .AbB (bit_bb)
   );

   assign fark  = bit_kb | bit_bb;
   assign kabul = (state == S_IDLE) && start;
   assign busy  = (state == S_COMPARE);
   assign done  = (state == S_DONE);

   // Next state and the decision of which result (if any) to load this cycle.
   always_comb begin
      next_state  = state;
      sonuc_yukle = 1'b0;
      sonuc_d     = SONUC_E;
      case (state)
         S_IDLE: begin
            if (start) next_state = S_COMPARE;
         end
         S_COMPARE: begin
            if ((ERKEN_BITIR != 0) && fark) begin
               sonuc_yukle = 1'b1;
               sonuc_d     = bit_kb ? SONUC_K : SONUC_B;
               next_state  = S_DONE;
            end else if (idx == '0) begin
               // idx==0 is tested before any decrement, so idx never wraps.
               sonuc_yukle = 1'b1;
               next_state  = S_DONE;
               if (karar_var)   sonuc_d = karar_kb ? SONUC_K : SONUC_B;
               else if (bit_eb) sonuc_d = SONUC_E;
               else             sonuc_d = bit_kb ? SONUC_K : SONUC_B;
            end
         end
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   // State register and result flags; flags cleared on accept, loaded on decision.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
         AkB   <= 1'b0;
         AeB   <= 1'b0;
         AbB   <= 1'b0;
      end else begin
         state <= next_state;
         if (kabul) begin
            AkB <= 1'b0;
            AeB <= 1'b0;
            AbB <= 1'b0;
         end else if (sonuc_yukle) begin
            {AkB, AeB, AbB} <= sonuc_bayrak(sonuc_d);
         end
      end
   end

   // Operand latch, bit index and sticky first-difference record (no reset needed).
   always_ff @(posedge clk) begin
      if (kabul) begin
         ra        <= A;
         rb        <= B;
         idx       <= IW'(N - 1);
         karar_var <= 1'b0;
         karar_kb  <= 1'b0;
      end else if (state == S_COMPARE) begin
         if (!sonuc_yukle) idx <= idx - 1'b1;
         if (fark && !karar_var) begin
            karar_var <= 1'b1;
            karar_kb  <= bit_kb;
         end
      end
   end

endmodule

// File: tb/tb_seri_karsilastirici_denetleyici.sv
// Bench for the serial comparator controller: two instances (early stop on,
// early stop off) share the same stimulus and are checked cycle by cycle.
module tb_seri_karsilastirici_denetleyici;
   import karsilastirici_pkg::*;

   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy1, done1, AkB1, AeB1, AbB1;
   logic         busy0, done0, AkB0, AeB0, AbB0;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   seri_karsilastirici_denetleyici #(.N(N), .ERKEN_BITIR(1)) dut1 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy1), .done(done1), .AkB(AkB1), .AeB(AeB1), .AbB(AbB1)
   );

   seri_karsilastirici_denetleyici #(.N(N), .ERKEN_BITIR(0)) dut0 (
      .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
      .busy(busy0), .done(done0), .AkB(AkB0), .AeB(AeB0), .AbB(AbB0)
   );

   // Expected flags {AkB,AeB,AbB} straight from unsigned magnitude.
   function automatic logic [2:0] beklenen_bayrak(input logic [N-1:0] a, input logic [N-1:0] b);
      sonuc_t s;
      if (a < b)       s = SONUC_K;
      else if (a == b) s = SONUC_E;
      else             s = SONUC_B;
      case (s)
         SONUC_K: return 3'b100;
         SONUC_E: return 3'b010;
         default: return 3'b001;
      endcase
   endfunction

   // Cycle (counted from 1 after the accepting edge) in which done is high.
   function automatic int bitis(input logic [N-1:0] a, input logic [N-1:0] b, input bit erken);
      logic [N-1:0] x;
      int k;
      x = a ^ b;
      if (!erken || x == '0) return N + 1;
      k = 0;
      for (int i = 0; i < N; i++) if (x[i]) k = i;
      return N + 1 - k;
   endfunction

   // Run one comparison; optionally re-pulse start with new operands at cycle rep.
   task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b, input int rep);
      logic [2:0] ef;
      int d1, d0;
      logic [4:0] exp1, exp0, got1, got0;
      ef = beklenen_bayrak(a, b);
      d1 = bitis(a, b, 1'b1);
      d0 = bitis(a, b, 1'b0);
      @(negedge clk);
      A = a; B = b; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      A = N'($urandom);
      B = N'($urandom);
      for (int c = 1; c <= N + 2; c++) begin
         @(negedge clk);
         exp1 = {(c < d1), (c == d1), (c >= d1) ? ef : 3'b000};
         exp0 = {(c < d0), (c == d0), (c >= d0) ? ef : 3'b000};
         got1 = {busy1, done1, AkB1, AeB1, AbB1};
         got0 = {busy0, done0, AkB0, AeB0, AbB0};
         total++;
         if (got1 !== exp1) begin
            bad++;
            $display("FAIL op_erken a=%h b=%h cyc=%0d got=%b want=%b", a, b, c, got1, exp1);
         end
         total++;
         if (got0 !== exp0) begin
            bad++;
            $display("FAIL op_tam a=%h b=%h cyc=%0d got=%b want=%b", a, b, c, got0, exp0);
         end
         if (c == rep) begin
            A = 8'h00; B = 8'hFF; start = 1'b1;
         end else if (rep != 0 && c == rep + 1) begin
            start = 1'b0;
         end
      end
   endtask

   task automatic check_zero(input string name);
      total++;
      if ({busy1, done1, AkB1, AeB1, AbB1} !== 5'b0) begin
         bad++;
         $display("FAIL %s erken got=%b want=00000", name, {busy1, done1, AkB1, AeB1, AbB1});
      end
      total++;
      if ({busy0, done0, AkB0, AeB0, AbB0} !== 5'b0) begin
         bad++;
         $display("FAIL %s tam got=%b want=00000", name, {busy0, done0, AkB0, AeB0, AbB0});
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; A = '0; B = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);
      check_zero("reset_idle");
   endtask

   task automatic test_directed();
      run_op(8'h00, 8'h00, 0);
      run_op(8'h80, 8'h7F, 0);
      run_op(8'h35, 8'h37, 0);
      run_op(8'hF0, 8'h0F, 0);
      run_op(8'hFF, 8'hFE, 0);
      run_op(8'h01, 8'h00, 0);
   endtask

   task automatic test_ignore_start();
      run_op(8'h35, 8'h37, 3);
      run_op(8'h5A, 8'h5A, 2);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      A = 8'h12; B = 8'h34; start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_zero("rst_mid");
      rst = 1'b0;
      @(negedge clk);
      check_zero("rst_mid_after");
      run_op(8'hC3, 8'hC3, 0);
      run_op(8'h12, 8'h34, 0);
   endtask

   task automatic test_rst_start();
      @(negedge clk);
      rst = 1'b1; start = 1'b1; A = 8'h01; B = 8'h02;
      @(negedge clk);
      check_zero("rst_start");
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      check_zero("rst_start_dropped");
   endtask

   task automatic test_back_to_back();
      logic [N-1:0] a, b;
      for (int i = 0; i < 24; i++) begin
         a = N'($urandom);
         case (i % 3)
            0: b = a;
            1: b = a ^ (N'(1) << $urandom_range(N - 1, 0));
            default: b = N'($urandom);
         endcase
         run_op(a, b, 0);
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_ignore_start();
      test_reset_mid();
      test_rst_start();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
